// File: rtl/clk_div_multi_if.sv
// Bus bundle for clk_div_multi: per-channel enables, sync strobe, config write port
// and the divided clock / tick outputs.
interface clk_div_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] en_in;
    logic                sync_in;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic [CNT_W-1:0]    cfg_high;
    logic                cfg_err;
    logic [CHANNELS-1:0] cfg_pend;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick_out;

    modport master (
        output en_in, sync_in, cfg_we, cfg_ch, cfg_div, cfg_high,
        input  cfg_err, cfg_pend, clk_out, tick_out
    );

    modport slave (
        input  en_in, sync_in, cfg_we, cfg_ch, cfg_div, cfg_high,
        output cfg_err, cfg_pend, clk_out, tick_out
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel divisor, high time, enable,
// period-start tick; new settings take effect only at a period boundary.
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24,
    parameter int DEF_DIV  = 12,
    parameter int DEF_HIGH = 6
) (
    input  logic            clk_in,
    input  logic            rst_in,
    clk_div_multi_if.slave  bus
);
    localparam int                CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MIN_DIV  = CNT_W'(2);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    logic [CH_W:0]       ch_ext;
    logic                cfg_bad;
    logic                cfg_ok;
    logic                cfg_err_q;
    logic [CHANNELS-1:0] pend_vec;
    logic [CHANNELS-1:0] clk_vec;
    logic [CHANNELS-1:0] tick_vec;

    // Channel index is widened by one bit so out-of-range targets can be detected.
    assign ch_ext  = {1'b0, bus.cfg_ch};
    assign cfg_bad = bus.cfg_we && ((bus.cfg_div < MIN_DIV) || (ch_ext >= CH_LIMIT));
    assign cfg_ok  = bus.cfg_we && !cfg_bad;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_bad;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

        state_e           state_q, state_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] high_q, high_d;
        logic [CNT_W-1:0] div_p_q, div_p_d;
        logic [CNT_W-1:0] high_p_q, high_p_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             apply;

        assign wr_hit = cfg_ok && (bus.cfg_ch == CH_IDX);

        // NOTE: every signal driven here gets a default first, so no path through
        // the block can leave one unassigned and infer a latch.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            div_d    = div_q;
            high_d   = high_q;
            div_p_d  = wr_hit ? bus.cfg_div  : div_p_q;
            high_p_d = wr_hit ? bus.cfg_high : high_p_q;
            pend_d   = pend_q | wr_hit;
            apply    = 1'b0;

            // Priority: disable > start > sync > wrap; each is a period boundary.
            if (!bus.en_in[g]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                apply   = 1'b1;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                apply   = 1'b1;
            end else if (bus.sync_in) begin
                cnt_d = '0;
                apply = 1'b1;
            end else if (cnt_q == (div_q - ONE)) begin
                cnt_d = '0;
                apply = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end

            // A write landing on a boundary cycle is folded in at that boundary.
            if (apply && pend_d) begin
                div_d  = div_p_d;
                high_d = high_p_d;
                pend_d = 1'b0;
            end

            clk_d  = (state_d == ST_RUN) && (cnt_d < high_d);
            tick_d = (state_d == ST_RUN) && (cnt_d == '0);
        end

        // NOTE: all channel state, including the config registers, is reset so the
        // defaults are known without an explicit write after power-up.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                state_q  <= ST_IDLE;
                div_q    <= CNT_W'(DEF_DIV);
                high_q   <= CNT_W'(DEF_HIGH);
                div_p_q  <= CNT_W'(DEF_DIV);
                high_p_q <= CNT_W'(DEF_HIGH);
                cnt_q    <= '0;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                div_q    <= div_d;
                high_q   <= high_d;
                div_p_q  <= div_p_d;
                high_p_q <= high_p_d;
                cnt_q    <= cnt_d;
                pend_q   <= pend_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
            end
        end

        assign pend_vec[g] = pend_q;
        assign clk_vec[g]  = clk_q;
        assign tick_vec[g] = tick_q;
    end

    assign bus.cfg_err  = cfg_err_q;
    assign bus.cfg_pend = pend_vec;
    assign bus.clk_out  = clk_vec;
    assign bus.tick_out = tick_vec;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: reset defaults, rate programming, boundary-aligned
// reconfiguration, duty edges, rejection, sync alignment, async reset and restart.
module tb_clk_div_multi;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    clk_div_multi_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(
        .CHANNELS(CHANNELS),
        .CNT_W   (CNT_W),
        .DEF_DIV (12),
        .DEF_HIGH(6)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Samples ch for n cycles starting at counter phase start and compares against D/H.
    task automatic expect_wave(input int ch, input int d, input int h, input int n,
                               input int start, input string name);
        int   c;
        logic ec, et;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c  = (start + i) % d;
            ec = (c < h);
            et = (c == 0);
            total++;
            if (bus.clk_out[ch] !== ec) begin
                bad++;
                $display("FAIL %s clk_out[%0d] cyc %0d: got %b want %b", name, ch, i, bus.clk_out[ch], ec);
            end
            total++;
            if (bus.tick_out[ch] !== et) begin
                bad++;
                $display("FAIL %s tick_out[%0d] cyc %0d: got %b want %b", name, ch, i, bus.tick_out[ch], et);
            end
        end
    endtask

    // Disable ch while writing D/H, then re-enable; the next negedge is the period start.
    task automatic write_disabled(input int ch, input int d, input int h);
        bus.en_in[ch] = 1'b0;
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_div   = CNT_W'(d);
        bus.cfg_high  = CNT_W'(h);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++;
        if (bus.clk_out[ch] !== 1'b0 || bus.tick_out[ch] !== 1'b0) begin
            bad++;
            $display("FAIL disabled_out[%0d]: got clk=%b tick=%b want 0/0", ch, bus.clk_out[ch], bus.tick_out[ch]);
        end
        total++;
        if (bus.cfg_pend[ch] !== 1'b0) begin
            bad++;
            $display("FAIL idle_apply pend[%0d]: got %b want 0", ch, bus.cfg_pend[ch]);
        end
        bus.en_in[ch] = 1'b1;
    endtask

    task automatic test_reset();
        bus.en_in   = '0;
        bus.sync_in = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.cfg_ch  = '0;
        bus.cfg_div = '0;
        bus.cfg_high = '0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.clk_out !== 4'b0 || bus.tick_out !== 4'b0) begin
            bad++;
            $display("FAIL reset_out: got clk=%b tick=%b want 0/0", bus.clk_out, bus.tick_out);
        end
        total++;
        if (bus.cfg_err !== 1'b0 || bus.cfg_pend !== 4'b0) begin
            bad++;
            $display("FAIL reset_cfg: got err=%b pend=%b want 0/0", bus.cfg_err, bus.cfg_pend);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.clk_out !== 4'b0 || bus.tick_out !== 4'b0) begin
            bad++;
            $display("FAIL idle_out: got clk=%b tick=%b want 0/0", bus.clk_out, bus.tick_out);
        end
    endtask

    task automatic test_default_ch0();
        bus.en_in[0] = 1'b1;
        expect_wave(0, 12, 6, 36, 0, "default_1mhz");
    endtask

    task automatic test_1khz();
        write_disabled(1, 12000, 6000);
        expect_wave(1, 12000, 6000, 24000, 0, "ch1_1khz");
        bus.en_in[1] = 1'b0;
    endtask

    task automatic test_cfg_midperiod();
        bus.en_in[2] = 1'b1;
        expect_wave(2, 12, 6, 4, 0, "ch2_pre");
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'd2;
        bus.cfg_div  = CNT_W'(5);
        bus.cfg_high = CNT_W'(2);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++;
        if (bus.cfg_pend[2] !== 1'b1) begin
            bad++;
            $display("FAIL pend_set[2]: got %b want 1", bus.cfg_pend[2]);
        end
        total++;
        if (bus.clk_out[2] !== 1'b1 || bus.tick_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL old_period[2]: got clk=%b tick=%b want 1/0", bus.clk_out[2], bus.tick_out[2]);
        end
        expect_wave(2, 12, 6, 7, 5, "ch2_old_tail");
        total++;
        if (bus.cfg_pend[2] !== 1'b1) begin
            bad++;
            $display("FAIL pend_hold[2]: got %b want 1", bus.cfg_pend[2]);
        end
        expect_wave(2, 5, 2, 15, 0, "ch2_new");
        total++;
        if (bus.cfg_pend[2] !== 1'b0) begin
            bad++;
            $display("FAIL pend_clear[2]: got %b want 0", bus.cfg_pend[2]);
        end
    endtask

    task automatic test_duty_edges();
        write_disabled(2, 5, 0);
        expect_wave(2, 5, 0, 10, 0, "duty_h0");
        write_disabled(2, 7, 7);
        expect_wave(2, 7, 7, 14, 0, "duty_full");
        write_disabled(2, 3, 1);
        expect_wave(2, 3, 1, 9, 0, "duty_third");
    endtask

    task automatic test_reject();
        // ch2 last sampled at counter 2 of its D=3 period.
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'd2;
        bus.cfg_div  = CNT_W'(1);
        bus.cfg_high = CNT_W'(1);
        @(negedge clk);
        total++;
        if (bus.cfg_err !== 1'b1 || bus.cfg_pend[2] !== 1'b0) begin
            bad++;
            $display("FAIL reject_div1: got err=%b pend=%b want 1/0", bus.cfg_err, bus.cfg_pend[2]);
        end
        total++;
        if (bus.tick_out[2] !== 1'b1) begin
            bad++;
            $display("FAIL reject_period: got tick=%b want 1", bus.tick_out[2]);
        end
        bus.cfg_ch  = 2'd3;
        bus.cfg_div = CNT_W'(0);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        total++;
        if (bus.cfg_err !== 1'b1 || bus.cfg_pend[3] !== 1'b0) begin
            bad++;
            $display("FAIL reject_div0: got err=%b pend=%b want 1/0", bus.cfg_err, bus.cfg_pend[3]);
        end
        @(negedge clk);
        total++;
        if (bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse: got %b want 0", bus.cfg_err);
        end
        expect_wave(2, 3, 1, 6, 0, "reject_keep");
    endtask

    task automatic test_sync();
        logic e0, e3;
        write_disabled(3, 8, 4);
        expect_wave(3, 8, 4, 5, 0, "ch3_pre");
        bus.sync_in = 1'b1;
        @(negedge clk);
        bus.sync_in = 1'b0;
        total++;
        if (bus.tick_out[0] !== 1'b1 || bus.tick_out[3] !== 1'b1) begin
            bad++;
            $display("FAIL sync_tick: got t0=%b t3=%b want 1/1", bus.tick_out[0], bus.tick_out[3]);
        end
        for (int i = 1; i <= 48; i++) begin
            @(negedge clk);
            e0 = ((i % 12) == 0);
            e3 = ((i % 8) == 0);
            total++;
            if (bus.tick_out[0] !== e0 || bus.tick_out[3] !== e3) begin
                bad++;
                $display("FAIL sync_align cyc %0d: got t0=%b t3=%b want %b/%b", i, bus.tick_out[0], bus.tick_out[3], e0, e3);
            end
        end
    endtask

    task automatic test_async_reset();
        // Ch0 is at counter 0 here, so clk_out[0] is high before the pulse.
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.clk_out !== 4'b0 || bus.tick_out !== 4'b0) begin
            bad++;
            $display("FAIL async_rst: got clk=%b tick=%b want 0/0", bus.clk_out, bus.tick_out);
        end
        #1 rst = 1'b0;
        expect_wave(0, 12, 6, 12, 0, "post_rst_ch0");
        total++;
        if (bus.cfg_pend !== 4'b0) begin
            bad++;
            $display("FAIL post_rst_pend: got %b want 0", bus.cfg_pend);
        end
    endtask

    task automatic test_disable_restart();
        expect_wave(0, 12, 6, 5, 0, "restart_pre");
        bus.en_in[0] = 1'b0;
        @(negedge clk);
        total++;
        if (bus.clk_out[0] !== 1'b0 || bus.tick_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL disable_out: got clk=%b tick=%b want 0/0", bus.clk_out[0], bus.tick_out[0]);
        end
        bus.en_in[0] = 1'b1;
        expect_wave(0, 12, 6, 24, 0, "restart_post");
    endtask

    initial begin
        test_reset();
        test_default_ch0();
        test_1khz();
        test_cfg_midperiod();
        test_duty_edges();
        test_reject();
        test_sync();
        test_async_reset();
        test_disable_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
